// File: rtl/fetch_pc_predictor_pkg.sv
// Shared definitions for the fetch PC predictor.
// Holds the RISC-V control-flow opcodes, 2-bit counter encodings and
// the saturating counter update helper.
package fetch_pc_predictor_pkg;

    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJal    = 7'h6F;
    localparam logic [6:0] OpJalr   = 7'h67;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    // Saturating up/down step of a 2-bit direction counter.
    function automatic ctr_e ctr_update(ctr_e c, logic taken);
        logic [1:0] v;
        v = c;
        if (taken && (v != 2'b11)) begin
            v = v + 2'b01;
        end else if (!taken && (v != 2'b00)) begin
            v = v - 2'b01;
        end
        return ctr_e'(v);
    endfunction

endpackage

// File: rtl/fetch_pc_predictor_btb_array.sv
// Direct-mapped BTB storage with one asynchronous lookup port and one
// synchronous training port. Training reads its own entry internally so
// the outside world sees a single read port.
// Ports:
//   clock, reset          - clock, async active-low clear of all entries
//   rd_idx                - lookup index
//   rd_valid/tag/target/ctr - lookup entry contents (pre-edge)
//   upd_en                - apply a resolved branch/jump this cycle
//   upd_idx/tag           - index/tag of the resolved instruction
//   upd_taken/jump        - outcome and jal/jalr flag
//   upd_target            - actual target
module fetch_pc_predictor_btb_array
    import fetch_pc_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDXW    = $clog2(ENTRIES),
    parameter int unsigned TAGW    = 30 - IDXW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_valid,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_target,
    output ctr_e            rd_ctr,
    input  logic            upd_en,
    input  logic [IDXW-1:0] upd_idx,
    input  logic [TAGW-1:0] upd_tag,
    input  logic            upd_taken,
    input  logic            upd_jump,
    input  logic [31:0]     upd_target
);

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    ctr_e            ctr_q    [ENTRIES];

    logic upd_hit;

    always_comb begin
        rd_valid  = valid_q[rd_idx];
        rd_tag    = tag_q[rd_idx];
        rd_target = target_q[rd_idx];
        rd_ctr    = ctr_q[rd_idx];
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CtrSnt;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_jump) begin
                    ctr_q[upd_idx]    <= CtrSt;
                    target_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= ctr_update(ctr_q[upd_idx], upd_taken);
                    if (upd_taken) begin
                        target_q[upd_idx] <= upd_target;
                    end
                end
            end else if (upd_taken) begin
                // Miss on a taken instruction replaces whatever lives there.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= upd_jump ? CtrSt : CtrWt;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch PC generation with BTB-based next-PC prediction.
// Ports:
//   clock, reset             - clock, async active-low reset
//   stall                    - hold the fetch PC
//   resolve*                 - branch/jump resolution from execute
//   pc                       - current fetch PC
//   predTaken, predTarget    - prediction for pc, carried down the pipe
//   flush                    - misprediction, squash IF/ID and ID/EX
module fetch_pc_predictor
    import fetch_pc_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        resolveValid,
    input  logic        resolveJump,
    input  logic [31:0] resolvePC,
    input  logic        resolveTaken,
    input  logic [31:0] resolveTarget,
    input  logic        resolvePredTaken,
    input  logic [31:0] resolvePredTarget,
    output logic [31:0] pc,
    output logic        predTaken,
    output logic [31:0] predTarget,
    output logic        flush
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = 30 - IDXW;

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     pc_plus4;
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [31:0]     rd_target;
    ctr_e            rd_ctr;
    logic            hit;
    logic            mispredict;

    fetch_pc_predictor_btb_array #(
        .ENTRIES (ENTRIES),
        .IDXW    (IDXW),
        .TAGW    (TAGW)
    ) u_btb (
        .clock      (clock),
        .reset      (reset),
        .rd_idx     (pc_q[IDXW+1:2]),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr     (rd_ctr),
        .upd_en     (resolveValid),
        .upd_idx    (resolvePC[IDXW+1:2]),
        .upd_tag    (resolvePC[31:IDXW+2]),
        .upd_taken  (resolveTaken),
        .upd_jump   (resolveJump),
        .upd_target (resolveTarget)
    );

    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        hit        = rd_valid && (rd_tag == pc_q[31:IDXW+2]);
        mispredict = resolveValid &&
                     ((resolveTaken != resolvePredTaken) ||
                      (resolveTaken && (resolveTarget != resolvePredTarget)));

        // Outputs are forced quiet while reset is held.
        predTaken  = reset && hit && rd_ctr[1];
        predTarget = !reset ? 32'h0 : (hit ? rd_target : pc_plus4);
        flush      = reset && mispredict;

        if (mispredict) begin
            pc_d = resolveTaken ? resolveTarget : (resolvePC + 32'd4);
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = predTaken ? predTarget : pc_plus4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule
